wasm_stack_core: RTL and testbench

Parametrised successor to the first-generation WASM execution core. It fetches opcodes over the byte-wide ROM/memory handshake and decodes signed and unsigned LEB128 immediates. Operand stack and locals are held in internal register files of configurable width and depth, instead of external memory. Adds sub/and/or/xor/local.tee, bounds checking with trap codes, and a clean halt. Sits between the WASM parser (which provides `rom_mapped` and `first_instruction`) and the shared memory arbiter.

---
 rtl/wasm_stack_core_pkg.sv | 47 ++++
 rtl/wasm_stack_core_if.sv | 14 +
 rtl/wasm_stack_core_operand_stack.sv | 55 +++++
 rtl/wasm_stack_core.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_wasm_stack_core.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/wasm_stack_core_pkg.sv
// Shared opcodes, state/trap encodings and LEB128 sizing helpers for the WASM stack core.
package wasm_pkg;

    localparam logic [7:0] OP_UNREACHABLE = 8'h00;
    localparam logic [7:0] OP_END         = 8'h0B;
    localparam logic [7:0] OP_DROP        = 8'h1A;
    localparam logic [7:0] OP_LOCAL_GET   = 8'h20;
    localparam logic [7:0] OP_LOCAL_SET   = 8'h21;
    localparam logic [7:0] OP_LOCAL_TEE   = 8'h22;
    localparam logic [7:0] OP_I_CONST     = 8'h41;
    localparam logic [7:0] OP_ADD         = 8'h6A;
    localparam logic [7:0] OP_SUB         = 8'h6B;
    localparam logic [7:0] OP_MUL         = 8'h6C;
    localparam logic [7:0] OP_AND         = 8'h71;
    localparam logic [7:0] OP_OR          = 8'h72;
    localparam logic [7:0] OP_XOR         = 8'h73;

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_IMM,
        S_EXEC,
        S_HALT,
        S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        TRAP_NONE        = 3'd0,
        TRAP_UNREACHABLE = 3'd1,
        TRAP_ILLEGAL     = 3'd2,
        TRAP_UNDERFLOW   = 3'd3,
        TRAP_OVERFLOW    = 3'd4,
        TRAP_BAD_LOCAL   = 3'd5,
        TRAP_BAD_LEB     = 3'd6
    } trap_e;

    // Fewest LEB128 bytes able to carry a value of the given bit width.
    function automatic int leb_bytes_max(input int width);
        return (width + 6) / 7;
    endfunction

    function automatic logic has_imm(input logic [7:0] op);
        return (op == OP_LOCAL_GET) || (op == OP_LOCAL_SET) ||
               (op == OP_LOCAL_TEE) || (op == OP_I_CONST);
    endfunction

endpackage

// File: rtl/wasm_stack_core_if.sv
// Byte-wide read handshake between the core (master) and the memory arbiter (slave).
interface wasm_stack_core_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read_en;
    logic [7:0]        mem_data_out;
    logic              mem_ready;

    modport master (output mem_addr, output mem_read_en,
                    input  mem_data_out, input mem_ready);
    modport slave  (input  mem_addr, input mem_read_en,
                    output mem_data_out, output mem_ready);
endinterface

// File: rtl/wasm_stack_core_operand_stack.sv
// Register-file operand stack; pops are applied before the push so a binary op works at full depth.
module wasm_operand_stack #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop1,
    input  logic                   i_pop2,
    input  logic [DATA_W-1:0]      i_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [DATA_W-1:0]      o_top,
    output logic [DATA_W-1:0]      o_second,
    output logic [$clog2(DEPTH):0] o_depth
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W:0]    r_depth;
    logic [PTR_W:0]    w_base;
    logic [PTR_W-1:0]  w_top_idx;
    logic [PTR_W-1:0]  w_sec_idx;

    always_comb begin
        w_base = r_depth;
        if (i_pop2)
            w_base = r_depth - (PTR_W+1)'(2);
        else if (i_pop1)
            w_base = r_depth - (PTR_W+1)'(1);
    end

    assign w_top_idx = PTR_W'(r_depth - (PTR_W+1)'(1));
    assign w_sec_idx = PTR_W'(r_depth - (PTR_W+1)'(2));

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[w_base[PTR_W-1:0]] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_depth <= '0;
        else if (i_push || i_pop1 || i_pop2)
            r_depth <= w_base + (PTR_W+1)'(i_push);
    end

    assign o_full   = (r_depth == (PTR_W+1)'(DEPTH));
    assign o_empty  = (r_depth == '0);
    assign o_top    = o_empty ? '0 : r_mem[w_top_idx];
    assign o_second = (r_depth < (PTR_W+1)'(2)) ? '0 : r_mem[w_sec_idx];
    assign o_depth  = r_depth;

endmodule

// File: rtl/wasm_stack_core.sv
// WASM stack execution core: byte fetch, LEB128 immediates, locals and trap/halt sequencing.
// Optional retired-instruction counter output is enabled with `define WASM_RETIRE_CNT_EN.
module wasm_stack_core
    import wasm_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int STACK_DEPTH = 16,
    parameter int NUM_LOCALS  = 8,
    parameter int LEB_MAX     = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_rom_mapped,
    input  logic [ADDR_W-1:0]            i_first_instruction,
    wasm_stack_core_if.master            mem,
    output logic                         o_halted,
    output logic                         o_trap,
    output logic [2:0]                   o_trap_code,
    output logic [ADDR_W-1:0]            o_trap_pc,
    output logic [$clog2(STACK_DEPTH):0] o_stack_depth,
    output logic [DATA_W-1:0]            o_stack_top
`ifdef WASM_RETIRE_CNT_EN
    ,
    output logic [31:0]                  o_retired
`endif
);
    localparam int LEB_N   = (LEB_MAX > leb_bytes_max(DATA_W)) ? LEB_MAX : leb_bytes_max(DATA_W);
    localparam int ACC_W   = 7 * LEB_N;
    localparam int LIDX_W  = (NUM_LOCALS > 1) ? $clog2(NUM_LOCALS) : 1;
    localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

    state_e            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_en;
    logic [7:0]        r_opcode;
    logic [ADDR_W-1:0] r_op_pc;
    logic [ACC_W-1:0]  r_imm;
    logic [3:0]        r_n;
    logic              r_halted;
    logic              r_trap;
    trap_e             r_trap_code;
    logic [ADDR_W-1:0] r_trap_pc;
    logic [DATA_W-1:0] r_locals [NUM_LOCALS];

    logic [7:0]         w_byte;
    logic               w_issue;
    logic               w_got;
    logic [ACC_W-1:0]   w_acc_next;
    logic [ACC_W-1:0]   w_acc_final;
    logic               w_leb_last;
    logic               w_idx_ok;
    logic [LIDX_W-1:0]  w_lidx;
    logic [DATA_W-1:0]  w_local_rd;
    logic               w_push;
    logic               w_pop1;
    logic               w_pop2;
    logic [DATA_W-1:0]  w_push_data;
    logic               w_local_wr;
    logic               w_exec_halt;
    trap_e              w_exec_trap;
    logic [DATA_W-1:0]  w_alu;
    logic               w_full;
    logic               w_empty;
    logic [DATA_W-1:0]  w_top;
    logic [DATA_W-1:0]  w_second;
    logic [DEPTH_W-1:0] w_depth;

    wasm_operand_stack #(
        .DATA_W (DATA_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_push),
        .i_pop1   (w_pop1),
        .i_pop2   (w_pop2),
        .i_data   (w_push_data),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_top    (w_top),
        .o_second (w_second),
        .o_depth  (w_depth)
    );

    assign w_byte  = mem.mem_data_out;
    assign w_issue = !r_rd_en && !mem.mem_ready;
    assign w_got   = r_rd_en && mem.mem_ready;

    // Only 0x41 immediates are sign-extended; local indices stay unsigned.
    assign w_acc_next  = r_imm | (ACC_W'(w_byte[6:0]) << (7 * r_n));
    assign w_acc_final = ((r_opcode == OP_I_CONST) && w_byte[6])
                       ? (w_acc_next | ({ACC_W{1'b1}} << (7 * (r_n + 4'd1))))
                       : w_acc_next;
    // A continuation bit on the last permitted byte means the count must exceed LEB_MAX.
    assign w_leb_last  = (r_n == 4'(LEB_MAX - 1));

    assign w_idx_ok   = (r_imm < ACC_W'(NUM_LOCALS));
    assign w_lidx     = r_imm[LIDX_W-1:0];
    assign w_local_rd = r_locals[w_lidx];

    always_comb begin
        w_alu = '0;
        case (r_opcode)
            OP_ADD:  w_alu = w_second + w_top;
            OP_SUB:  w_alu = w_second - w_top;
            OP_MUL:  w_alu = w_second * w_top;
            OP_AND:  w_alu = w_second & w_top;
            OP_OR:   w_alu = w_second | w_top;
            OP_XOR:  w_alu = w_second ^ w_top;
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_push      = 1'b0;
        w_pop1      = 1'b0;
        w_pop2      = 1'b0;
        w_push_data = '0;
        w_local_wr  = 1'b0;
        w_exec_halt = 1'b0;
        w_exec_trap = TRAP_NONE;
        if (r_state == S_EXEC) begin
            case (r_opcode)
                OP_UNREACHABLE: w_exec_trap = TRAP_UNREACHABLE;
                OP_END:         w_exec_halt = 1'b1;
                OP_DROP: begin
                    if (w_empty) w_exec_trap = TRAP_UNDERFLOW;
                    else         w_pop1      = 1'b1;
                end
                OP_LOCAL_GET: begin
                    if (!w_idx_ok)  w_exec_trap = TRAP_BAD_LOCAL;
                    else if (w_full) w_exec_trap = TRAP_OVERFLOW;
                    else begin
                        w_push      = 1'b1;
                        w_push_data = w_local_rd;
                    end
                end
                OP_LOCAL_SET: begin
                    if (!w_idx_ok)   w_exec_trap = TRAP_BAD_LOCAL;
                    else if (w_empty) w_exec_trap = TRAP_UNDERFLOW;
                    else begin
                        w_pop1     = 1'b1;
                        w_local_wr = 1'b1;
                    end
                end
                OP_LOCAL_TEE: begin
                    if (!w_idx_ok)   w_exec_trap = TRAP_BAD_LOCAL;
                    else if (w_empty) w_exec_trap = TRAP_UNDERFLOW;
                    else             w_local_wr  = 1'b1;
                end
                OP_I_CONST: begin
                    if (w_full) w_exec_trap = TRAP_OVERFLOW;
                    else begin
                        w_push      = 1'b1;
                        w_push_data = r_imm[DATA_W-1:0];
                    end
                end
                OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
                    if (w_depth < DEPTH_W'(2)) w_exec_trap = TRAP_UNDERFLOW;
                    else begin
                        w_pop2      = 1'b1;
                        w_push      = 1'b1;
                        w_push_data = w_alu;
                    end
                end
                default: w_exec_trap = TRAP_ILLEGAL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LOCALS; i++)
                r_locals[i] <= '0;
        end else if (w_local_wr) begin
            r_locals[w_lidx] <= w_top;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_BOOT;
            r_pc        <= '0;
            r_addr      <= '0;
            r_rd_en     <= 1'b0;
            r_opcode    <= '0;
            r_op_pc     <= '0;
            r_imm       <= '0;
            r_n         <= '0;
            r_halted    <= 1'b0;
            r_trap      <= 1'b0;
            r_trap_code <= TRAP_NONE;
            r_trap_pc   <= '0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    if (i_rom_mapped) begin
                        r_pc    <= i_first_instruction;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_issue) begin
                        r_rd_en <= 1'b1;
                        r_addr  <= r_pc;
                    end else if (w_got) begin
                        r_rd_en  <= 1'b0;
                        r_opcode <= w_byte;
                        r_op_pc  <= r_pc;
                        r_pc     <= r_pc + ADDR_W'(1);
                        r_imm    <= '0;
                        r_n      <= '0;
                        r_state  <= has_imm(w_byte) ? S_IMM : S_EXEC;
                    end
                end
                S_IMM: begin
                    if (w_issue) begin
                        r_rd_en <= 1'b1;
                        r_addr  <= r_pc;
                    end else if (w_got) begin
                        r_rd_en <= 1'b0;
                        r_pc    <= r_pc + ADDR_W'(1);
                        r_n     <= r_n + 4'd1;
                        if (w_byte[7]) begin
                            r_imm <= w_acc_next;
                            if (w_leb_last) begin
                                r_trap      <= 1'b1;
                                r_trap_code <= TRAP_BAD_LEB;
                                r_trap_pc   <= r_op_pc;
                                r_state     <= S_TRAP;
                            end
                        end else begin
                            r_imm   <= w_acc_final;
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (w_exec_trap != TRAP_NONE) begin
                        r_trap      <= 1'b1;
                        r_trap_code <= w_exec_trap;
                        r_trap_pc   <= r_op_pc;
                        r_state     <= S_TRAP;
                    end else if (w_exec_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_BOOT;
            endcase
        end
    end

`ifdef WASM_RETIRE_CNT_EN
    logic [31:0] r_retired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_retired <= '0;
        else if ((r_state == S_EXEC) && (w_exec_trap == TRAP_NONE))
            r_retired <= r_retired + 32'd1;
    end

    assign o_retired = r_retired;
`endif

    assign mem.mem_addr    = r_addr;
    assign mem.mem_read_en = r_rd_en;
    assign o_halted        = r_halted;
    assign o_trap          = r_trap;
    assign o_trap_code     = r_trap_code;
    assign o_trap_pc       = r_trap_pc;
    assign o_stack_depth   = w_depth;
    assign o_stack_top     = w_top;

endmodule

// File: tb/tb_wasm_stack_core.sv
// Directed programs against wasm_stack_core (STACK_DEPTH=4) with a random-wait-state byte memory.
module tb_wasm_stack_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rom_mapped;
    logic [31:0] first_instruction;
    logic        halted;
    logic        trap;
    logic [2:0]  trap_code;
    logic [31:0] trap_pc;
    logic [2:0]  stack_depth;
    logic [31:0] stack_top;
`ifdef WASM_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    wasm_stack_core_if #(.ADDR_W(32)) mif ();

    wasm_stack_core #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .STACK_DEPTH (4),
        .NUM_LOCALS  (8),
        .LEB_MAX     (5)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_rom_mapped        (rom_mapped),
        .i_first_instruction (first_instruction),
        .mem                 (mif.master),
        .o_halted            (halted),
        .o_trap              (trap),
        .o_trap_code         (trap_code),
        .o_trap_pc           (trap_pc),
        .o_stack_depth       (stack_depth),
        .o_stack_top         (stack_top)
`ifdef WASM_RETIRE_CNT_EN
        ,
        .o_retired           (retired)
`endif
    );

    logic [7:0] rom [256];
    logic [7:0] q [$];
    int nvec = 0;
    int nerr = 0;

    // Memory model: answers each request after 0..5 wait states, ready pulses for one cycle.
    initial begin
        int wait_left;
        wait_left         = 0;
        mif.mem_ready     = 1'b0;
        mif.mem_data_out  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst || mif.mem_ready) begin
                mif.mem_ready = 1'b0;
            end else if (mif.mem_read_en) begin
                if (wait_left == 0) begin
                    mif.mem_data_out = rom[mif.mem_addr[7:0]];
                    mif.mem_ready    = 1'b1;
                    wait_left        = $urandom_range(0, 5);
                end else begin
                    wait_left--;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] base);
        rst        = 1'b1;
        rom_mapped = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        foreach (q[i]) rom[base[7:0] + 8'(i)] = q[i];
        repeat (2) @(negedge clk);
        rst               = 1'b0;
        first_instruction = base;
        @(negedge clk);
        rom_mapped = 1'b1;
    endtask

    task automatic finish_run();
        int cyc;
        cyc = 0;
        while (!(halted || trap) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("terminates", 64'(cyc < 2000), 64'd1);
        @(negedge clk);
    endtask

    task automatic run(input logic [31:0] base);
        start(base);
        finish_run();
    endtask

    initial begin
        int cyc;
        rst               = 1'b1;
        rom_mapped        = 1'b0;
        first_instruction = 32'h0;
        #1;
        chk("rst_read_en", 64'(mif.mem_read_en), 64'd0);
        chk("rst_addr",    64'(mif.mem_addr),    64'd0);
        chk("rst_halted",  64'(halted),          64'd0);
        chk("rst_trap",    64'(trap),            64'd0);
        chk("rst_code",    64'(trap_code),       64'd0);
        chk("rst_trap_pc", 64'(trap_pc),         64'd0);
        chk("rst_depth",   64'(stack_depth),     64'd0);
        chk("rst_top",     64'(stack_top),       64'd0);

        q = {8'h41, 8'h05, 8'h41, 8'h07, 8'h6A, 8'h0B};
        run(32'h10);
        chk("add_halted", 64'(halted),      64'd1);
        chk("add_trap",   64'(trap),        64'd0);
        chk("add_depth",  64'(stack_depth), 64'd1);
        chk("add_top",    64'(stack_top),   64'h0000000C);
        chk("add_rd_en",  64'(mif.mem_read_en), 64'd0);
`ifdef WASM_RETIRE_CNT_EN
        chk("add_retired", 64'(retired), 64'd4);
`endif

        q = {8'h41, 8'h7F, 8'h0B};
        run(32'h0);
        chk("neg1_top", 64'(stack_top), 64'hFFFFFFFF);

        q = {8'h41, 8'hE5, 8'h8E, 8'h26, 8'h0B};
        run(32'h0);
        chk("leb3_top", 64'(stack_top), 64'h00098765);

        q = {8'h41, 8'h2A, 8'h21, 8'h01, 8'h20, 8'h01, 8'h20, 8'h01, 8'h6C, 8'h0B};
        run(32'h0);
        chk("mul_top",   64'(stack_top),   64'd1764);
        chk("mul_depth", 64'(stack_depth), 64'd1);

        q = {8'h41, 8'h09, 8'h22, 8'h03, 8'h41, 8'h0E, 8'h20, 8'h03, 8'h6B, 8'h0B};
        run(32'h0);
        chk("tee_top",   64'(stack_top),   64'd5);
        chk("tee_depth", 64'(stack_depth), 64'd2);

        q = {8'h41, 8'h03, 8'h41, 8'h05, 8'h6B, 8'h0B};
        run(32'h0);
        chk("subneg_top", 64'(stack_top), 64'hFFFFFFFE);

        q = {8'h41, 8'h0C, 8'h41, 8'h0A, 8'h71, 8'h41, 8'h05, 8'h72, 8'h41, 8'h06, 8'h73, 8'h0B};
        run(32'h0);
        chk("logic_top", 64'(stack_top), 64'h0000000B);

        q = {8'h41, 8'h03, 8'h41, 8'h04, 8'h1A, 8'h0B};
        run(32'h0);
        chk("drop_top",   64'(stack_top),   64'd3);
        chk("drop_depth", 64'(stack_depth), 64'd1);

        q = {8'h41, 8'h03, 8'h21, 8'h08};
        run(32'h0);
        chk("badloc_code",  64'(trap_code),   64'd5);
        chk("badloc_pc",    64'(trap_pc),     64'd2);
        chk("badloc_depth", 64'(stack_depth), 64'd1);
        chk("badloc_top",   64'(stack_top),   64'd3);
        chk("badloc_halt",  64'(halted),      64'd0);

        q = {8'h6A};
        run(32'h20);
        chk("under_trap",  64'(trap),        64'd1);
        chk("under_code",  64'(trap_code),   64'd3);
        chk("under_pc",    64'(trap_pc),     64'h20);
        chk("under_depth", 64'(stack_depth), 64'd0);
        chk("under_rd_en", 64'(mif.mem_read_en), 64'd0);

        q = {8'hFF};
        run(32'h0);
        chk("illegal_code", 64'(trap_code), 64'd2);

        q = {8'h00};
        run(32'h0);
        chk("unreach_code", 64'(trap_code), 64'd1);

        q = {8'h41, 8'h01, 8'h41, 8'h01, 8'h41, 8'h01, 8'h41, 8'h01, 8'h41, 8'h01};
        run(32'h0);
        chk("over_code",  64'(trap_code),   64'd4);
        chk("over_pc",    64'(trap_pc),     64'd8);
        chk("over_depth", 64'(stack_depth), 64'd4);

        q = {8'h41, 8'h01, 8'h41, 8'h02, 8'h41, 8'h03, 8'h41, 8'h04, 8'h6A, 8'h0B};
        run(32'h0);
        chk("fulladd_halt",  64'(halted),      64'd1);
        chk("fulladd_depth", 64'(stack_depth), 64'd3);
        chk("fulladd_top",   64'(stack_top),   64'd7);

        q = {8'h41, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run(32'h0);
        chk("leb_code", 64'(trap_code), 64'd6);
        chk("leb_pc",   64'(trap_pc),   64'd0);

        // Reset while the core is requesting the second immediate byte.
        q = {8'h41, 8'hE5, 8'h8E, 8'h26, 8'h0B};
        start(32'h0);
        cyc = 0;
        while (!(mif.mem_read_en && mif.mem_addr == 32'd2) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_imm", 64'(cyc < 500), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_rd_en", 64'(mif.mem_read_en), 64'd0);
        chk("midrst_addr",  64'(mif.mem_addr),    64'd0);
        chk("midrst_trap",  64'(trap),            64'd0);
        chk("midrst_depth", 64'(stack_depth),     64'd0);
        chk("midrst_top",   64'(stack_top),       64'd0);
        run(32'h0);
        chk("restart_halt", 64'(halted),    64'd1);
        chk("restart_top",  64'(stack_top), 64'h00098765);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
